regfile_port_arbiter: RTL and testbench

Shares the single write port and the shared `dst` address port of `register_file` between `NUM_REQ` write requesters and one `dst`-port reader. Write requesters are served by round-robin arbitration through a one-entry registered write stage. The reader is protected from starvation by a bounded wait counter. Same-cycle write data is forwarded onto the `src` read path. The block sits between the execute/writeback units and `register_file`.

---
 rtl/regfile_port_arbiter.sv | 92 +++++++++
 tb/tb_regfile_port_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_port_arbiter.sv
// rtl/regfile_port_arbiter.sv - round-robin write-port arbiter with dst-read starvation guard and src forwarding
module regfile_port_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int DATA_W       = 64,
  parameter int ADDR_W       = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      rd_dst_valid,
  input  logic [ADDR_W-1:0]         rd_dst_addr,
  output logic                      rd_dst_ready,
  output logic [DATA_W-1:0]         rd_dst_data,
  input  logic [ADDR_W-1:0]         rd_src_addr,
  output logic [DATA_W-1:0]         rd_src_data,
  output logic                      rf_writeEnable,
  output logic [ADDR_W-1:0]         rf_dst,
  output logic [ADDR_W-1:0]         rf_src,
  output logic [DATA_W-1:0]         rf_dstWrite,
  input  logic [DATA_W-1:0]         rf_dstRead,
  input  logic [DATA_W-1:0]         rf_srcRead
);
  localparam int RR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [RR_W-1:0]   rr;
  logic [SC_W-1:0]   starve_cnt;

  logic [RR_W-1:0]   cand;
  logic [RR_W-1:0]   win_idx;
  logic              found;
  logic              blocked;
  logic              grant_any;

  // Scan requesters starting at the round-robin pointer; first valid one wins.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = RR_W'((int'(rr) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
  end

  assign blocked   = (starve_cnt >= SC_W'(STARVE_LIMIT));
  assign grant_any = found & ~blocked & ~rst;
  assign req_ready = grant_any ? (ONE_HOT0 << win_idx) : '0;

  // The dst port is lent to the reader only in cycles without a pending write.
  assign rd_dst_ready   = rd_dst_valid & ~wr_en;
  assign rd_dst_data    = rf_dstRead;
  assign rf_writeEnable = wr_en;
  assign rf_dst         = wr_en ? wr_addr : rd_dst_addr;
  assign rf_dstWrite    = wr_data;
  assign rf_src         = rd_src_addr;
  assign rd_src_data    = (wr_en && (rd_src_addr == wr_addr)) ? wr_data : rf_srcRead;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      rr         <= '0;
      starve_cnt <= '0;
    end else begin
      wr_en <= grant_any;
      if (grant_any) begin
        wr_addr <= req_addr[win_idx*ADDR_W +: ADDR_W];
        wr_data <= req_data[win_idx*DATA_W +: DATA_W];
        rr      <= (win_idx == RR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
      end
      if (rd_dst_valid && !rd_dst_ready) begin
        starve_cnt <= blocked ? starve_cnt : starve_cnt + 1'b1;
      end else begin
        starve_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// tb/tb_regfile_port_arbiter.sv - directed bench with per-cycle behavioural model for regfile_port_arbiter
module tb_regfile_port_arbiter;
  localparam int NUM_REQ      = 2;
  localparam int DATA_W       = 64;
  localparam int ADDR_W       = 4;
  localparam int STARVE_LIMIT = 4;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      rd_dst_valid;
  logic [ADDR_W-1:0]         rd_dst_addr;
  logic                      rd_dst_ready;
  logic [DATA_W-1:0]         rd_dst_data;
  logic [ADDR_W-1:0]         rd_src_addr;
  logic [DATA_W-1:0]         rd_src_data;
  logic                      rf_writeEnable;
  logic [ADDR_W-1:0]         rf_dst;
  logic [ADDR_W-1:0]         rf_src;
  logic [DATA_W-1:0]         rf_dstWrite;
  logic [DATA_W-1:0]         rf_dstRead;
  logic [DATA_W-1:0]         rf_srcRead;

  regfile_port_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
    .rd_dst_valid(rd_dst_valid), .rd_dst_addr(rd_dst_addr), .rd_dst_ready(rd_dst_ready),
    .rd_dst_data(rd_dst_data), .rd_src_addr(rd_src_addr), .rd_src_data(rd_src_data),
    .rf_writeEnable(rf_writeEnable), .rf_dst(rf_dst), .rf_src(rf_src), .rf_dstWrite(rf_dstWrite),
    .rf_dstRead(rf_dstRead), .rf_srcRead(rf_srcRead)
  );

  always #5 clk = ~clk;

  // register_file stand-in: combinational reads, write on the rising edge
  logic              mem_clear = 1'b1;
  logic [DATA_W-1:0] rf_mem [16];
  assign rf_dstRead = rf_mem[rf_dst];
  assign rf_srcRead = rf_mem[rf_src];
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 16; i++) rf_mem[i] <= '0;
    end else if (rf_writeEnable) begin
      rf_mem[rf_dst] <= rf_dstWrite;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: one pending write, a priority pointer, a blocked-read counter.
  logic [63:0] m_regs [16];
  logic        m_wv;
  logic [3:0]  m_wa;
  logic [63:0] m_wd;
  int          m_rr;
  int          m_starve;

  initial begin : model
    int          g;
    logic [1:0]  e_ready;
    logic        e_dr;
    logic [3:0]  e_dst;
    logic [63:0] e_src;
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    m_wv = 1'b0; m_wa = '0; m_wd = '0; m_rr = 0; m_starve = 0;
    forever begin
      @(negedge clk);
      g = -1;
      if (!rst && m_starve < STARVE_LIMIT) begin
        for (int k = 0; k < NUM_REQ; k++) begin
          if (g < 0 && req_valid[(m_rr + k) % NUM_REQ]) g = (m_rr + k) % NUM_REQ;
        end
      end
      e_ready = '0;
      if (g >= 0) e_ready[g] = 1'b1;
      e_dr  = rd_dst_valid && !m_wv;
      e_dst = m_wv ? m_wa : rd_dst_addr;
      e_src = (m_wv && rd_src_addr == m_wa) ? m_wd : m_regs[rd_src_addr];
      chk("cmp_req_ready", req_ready, e_ready);
      chk("cmp_rd_dst_ready", rd_dst_ready, e_dr);
      chk("cmp_rf_writeEnable", rf_writeEnable, m_wv);
      chk("cmp_rf_dst", rf_dst, e_dst);
      chk("cmp_rf_src", rf_src, rd_src_addr);
      chk("cmp_rf_dstWrite", rf_dstWrite, m_wd);
      chk("cmp_rd_src_data", rd_src_data, e_src);
      if (e_dr) chk("cmp_rd_dst_data", rd_dst_data, m_regs[e_dst]);
      if (m_wv) m_regs[m_wa] = m_wd;
      if (rst) begin
        m_wv = 1'b0; m_wa = '0; m_wd = '0; m_rr = 0; m_starve = 0;
      end else begin
        if (rd_dst_valid && m_wv) m_starve = (m_starve < STARVE_LIMIT) ? m_starve + 1 : m_starve;
        else                      m_starve = 0;
        if (g >= 0) begin
          m_wv = 1'b1;
          m_wa = req_addr[g*ADDR_W +: ADDR_W];
          m_wd = req_data[g*DATA_W +: DATA_W];
          m_rr = (g + 1) % NUM_REQ;
        end else begin
          m_wv = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [3:0] a, input logic [63:0] d);
    req_valid[i]                = v;
    req_addr[i*ADDR_W +: ADDR_W] = a;
    req_data[i*DATA_W +: DATA_W] = d;
  endtask

  function automatic logic [63:0] dval(input int k);
    return 64'h0123_4567_89AB_CDEF ^ (64'(k) * 64'h0101_0101_0101_0101);
  endfunction

  localparam logic [63:0] V1 = 64'h1C8F_BCBF_B54D_70F0;
  localparam logic [63:0] V5 = 64'h5555_0000_1234_5678;
  localparam logic [63:0] VA = 64'hAAAA_AAAA_AAAA_AAAA;

  initial begin : main
    logic [63:0] prev;
    logic [7:0]  rdv_pat;
    rst = 1'b1; req_valid = 2'b11; req_addr = '0; req_data = '0;
    rd_dst_valid = 1'b0; rd_dst_addr = 4'd6; rd_src_addr = '0;
    tick();
    mem_clear = 1'b0;
    @(negedge clk);
    chk("reset_we", rf_writeEnable, 0);
    chk("reset_ready", req_ready, 0);
    chk("reset_dstwrite", rf_dstWrite, 0);
    chk("reset_dst", rf_dst, 6);
    tick();
    rst = 1'b0; req_valid = '0;

    // single write, forwarded then read from the register file
    set_req(0, 1'b1, 4'd3, V1); rd_src_addr = 4'd3;
    @(negedge clk); chk("t1_grant", req_ready, 2'b01);
    tick(); set_req(0, 1'b0, 4'd0, 64'd0);
    @(negedge clk);
    chk("t1_we", rf_writeEnable, 1);
    chk("t1_dst", rf_dst, 3);
    chk("t1_dstwrite", rf_dstWrite, V1);
    chk("t1_src_fwd", rd_src_data, V1);
    tick();
    @(negedge clk);
    chk("t1_we_off", rf_writeEnable, 0);
    chk("t1_src_rf", rd_src_data, V1);
    tick();
    set_req(1, 1'b1, 4'd5, V5);
    @(negedge clk); chk("t1b_grant1", req_ready, 2'b10);
    tick(); set_req(1, 1'b0, 4'd0, 64'd0);

    // both requesters continuously, same target address
    rd_src_addr = 4'd10;
    for (int k = 0; k < 6; k++) begin
      set_req(0, 1'b1, 4'd10, 64'hD0 + 64'(k));
      set_req(1, 1'b1, 4'd10, 64'hE0 + 64'(k));
      @(negedge clk);
      chk("t2_grant", req_ready, (k % 2) ? 2'b10 : 2'b01);
      if (k > 0) begin
        prev = ((k - 1) % 2) ? 64'hE0 + 64'(k - 1) : 64'hD0 + 64'(k - 1);
        chk("t2_we", rf_writeEnable, 1);
        chk("t2_fwd", rd_src_data, prev);
      end
      tick();
    end
    req_valid = '0;
    @(negedge clk); chk("t2_last_we", rf_writeEnable, 1); chk("t2_last_fwd", rd_src_data, 64'hE5);
    tick();
    @(negedge clk); chk("t2_final_rf", rd_src_data, 64'hE5);
    tick();

    // starvation: writes keep coming while a dst read waits
    set_req(0, 1'b1, 4'd12, 64'hC0); rd_dst_addr = 4'd5;
    @(negedge clk); chk("t3_pre_grant", req_ready, 2'b01);
    tick();
    rd_dst_valid = 1'b1;
    for (int b = 1; b <= 6; b++) begin
      set_req(0, 1'b1, 4'd12, 64'hC0 + 64'(b));
      @(negedge clk);
      if (b <= 4) begin
        chk("t3_blocked", rd_dst_ready, 0);
        chk("t3_grant", req_ready, 2'b01);
      end else if (b == 5) begin
        chk("t3_limit_ready", req_ready, 2'b00);
        chk("t3_limit_blocked", rd_dst_ready, 0);
      end else begin
        chk("t3_read_go", rd_dst_ready, 1);
        chk("t3_read_data", rd_dst_data, V5);
        chk("t3_read_we", rf_writeEnable, 0);
      end
      tick();
    end

    // dropping rd_dst_valid while blocked must restart the count
    rdv_pat = 8'b1111_0110;
    for (int c = 0; c < 8; c++) begin
      rd_dst_valid = rdv_pat[c];
      @(negedge clk); chk("t3_clear_grant", req_ready, 2'b01);
      tick();
    end
    req_valid = '0; rd_dst_valid = 1'b0;
    @(negedge clk); tick();

    // fill all 16 registers from alternating requesters, then read back
    for (int k = 0; k < 16; k++) begin
      set_req(k % 2, 1'b1, 4'(k), dval(k));
      set_req(1 - (k % 2), 1'b0, 4'd0, 64'd0);
      @(negedge clk); chk("t4_grant", req_ready, (k % 2) ? 2'b10 : 2'b01);
      tick();
    end
    req_valid = '0;
    @(negedge clk); tick();
    for (int k = 0; k < 16; k++) begin
      rd_dst_valid = 1'b1; rd_dst_addr = 4'(k); rd_src_addr = 4'(k);
      @(negedge clk);
      chk("t4_dst_ready", rd_dst_ready, 1);
      chk("t4_dst_data", rd_dst_data, dval(k));
      chk("t4_src_data", rd_src_data, dval(k));
      tick();
    end
    rd_dst_valid = 1'b0;

    // reset while a write is being driven, then arbitration restart
    rd_src_addr = 4'd2;
    set_req(0, 1'b1, 4'd7, VA);
    @(negedge clk); chk("t5_grant", req_ready, 2'b01);
    tick();
    rst = 1'b1; set_req(1, 1'b1, 4'd9, 64'h99); rd_dst_addr = 4'd4;
    @(negedge clk);
    chk("t5_rst_we", rf_writeEnable, 1);
    chk("t5_rst_dst", rf_dst, 7);
    chk("t5_rst_ready", req_ready, 2'b00);
    tick();
    rst = 1'b0; set_req(0, 1'b0, 4'd0, 64'd0); set_req(1, 1'b1, 4'd9, 64'h9999);
    @(negedge clk);
    chk("t5_post_we", rf_writeEnable, 0);
    chk("t5_post_dstwrite", rf_dstWrite, 0);
    chk("t5_post_dst", rf_dst, 4);
    chk("t6_req1_only", req_ready, 2'b10);
    tick();
    set_req(0, 1'b1, 4'd11, 64'hBB); set_req(1, 1'b1, 4'd9, 64'h98);
    @(negedge clk);
    chk("t6_rr_zero", req_ready, 2'b01);
    chk("t6_we", rf_writeEnable, 1);
    chk("t6_dst", rf_dst, 9);
    tick();
    req_valid = '0;
    @(negedge clk); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
